// File: rtl/trigger_capture_if.sv
// Bundles the configuration bus and the two sample streams of trigger_capture.
// The slave modport is the capture block; the master modport is whatever feeds it.
interface trigger_capture_if #(
    parameter int SEW = 2,
    parameter int SDW = 32,
    parameter int BAW = 4,
    parameter int BDW = 32
);
    logic           bus_wready;
    logic           bus_wvalid;
    logic [BAW-1:0] bus_waddr;
    logic [BDW-1:0] bus_wdata;

    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;

    logic           sto_tready;
    logic           sto_tvalid;
    logic [SDW-1:0] sto_tdata;
    logic           sto_tlast;

    modport slave (
        output bus_wready,
        input  bus_wvalid, bus_waddr, bus_wdata,
        output sti_tready,
        input  sti_tvalid, sti_tevent, sti_tdata,
        input  sto_tready,
        output sto_tvalid, sto_tdata, sto_tlast
    );

    modport master (
        input  bus_wready,
        output bus_wvalid, bus_waddr, bus_wdata,
        input  sti_tready,
        output sti_tvalid, sti_tevent, sti_tdata,
        output sto_tready,
        input  sto_tvalid, sto_tdata, sto_tlast
    );
endinterface

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture into a circular buffer, then oldest-first
// readout through a registered memory port, an output register and a skid slot.
module trigger_capture #(
    parameter int SDW = 32,
    parameter int MAW = 10,
    parameter int BAW = 4
) (
    input  logic              clk,
    input  logic              rst,
    trigger_capture_if.slave  io,
    output logic [2:0]        sts_state
);
    localparam logic [MAW:0] FILL_MAX = {1'b1, {MAW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        READ  = 3'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [MAW-1:0] wptr_reg, wptr_next;
    logic [MAW-1:0] rptr_reg, rptr_next;
    logic [MAW:0]   fill_reg, fill_next;
    logic [MAW:0]   rem_reg, rem_next;
    logic [31:0]    cfg_post_reg, cfg_post_next;
    logic [31:0]    pcnt_reg, pcnt_next;
    logic           pend_reg, pend_next;
    logic           pend_last_reg, pend_last_next;
    logic           out_valid_reg, out_valid_next;
    logic [SDW-1:0] out_data_reg, out_data_next;
    logic           out_last_reg, out_last_next;
    logic           skid_valid_reg, skid_valid_next;
    logic [SDW-1:0] skid_data_reg, skid_data_next;
    logic           skid_last_reg, skid_last_next;

    logic [SDW-1:0] mem [0:(1<<MAW)-1];
    logic [SDW-1:0] mem_q;
    logic           mem_we;
    logic           issue;
    logic           enter_read;
    logic           pop;
    logic [1:0]     held;
    logic           o_v, s_v;

    logic ctl_wr, ctl_arm, ctl_abort, cfg_wr, ev_abort;

    assign ctl_wr    = io.bus_wvalid && (io.bus_waddr == BAW'(0));
    assign cfg_wr    = io.bus_wvalid && (io.bus_waddr == BAW'(1));
    assign ctl_arm   = ctl_wr && io.bus_wdata[0];
    assign ctl_abort = ctl_wr && io.bus_wdata[1];
    assign ev_abort  = io.sti_tvalid && io.sti_tevent[1];

    assign io.bus_wready = 1'b1;
    assign io.sti_tready = 1'b1;
    assign io.sto_tvalid = out_valid_reg;
    assign io.sto_tdata  = out_data_reg;
    assign io.sto_tlast  = out_last_reg;
    assign sts_state     = state_reg;

    always_comb begin
        state_next      = state_reg;
        wptr_next       = wptr_reg;
        rptr_next       = rptr_reg;
        fill_next       = fill_reg;
        rem_next        = rem_reg;
        cfg_post_next   = cfg_wr ? io.bus_wdata[31:0] : cfg_post_reg;
        pcnt_next       = pcnt_reg;
        pend_next       = 1'b0;
        pend_last_next  = pend_last_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;
        mem_we          = 1'b0;
        issue           = 1'b0;
        enter_read      = 1'b0;
        pop             = out_valid_reg && io.sto_tready;
        held            = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(pend_reg) - 2'(pop);
        o_v             = out_valid_reg;
        s_v             = skid_valid_reg;

        case (state_reg)
            IDLE: begin
                if (ctl_arm && !ctl_abort) begin
                    state_next = ARMED;
                    wptr_next  = '0;
                    fill_next  = '0;
                end
            end
            ARMED, POST: begin
                if (ctl_abort || ev_abort) begin
                    state_next = IDLE;
                end else if (io.sti_tvalid) begin
                    mem_we    = 1'b1;
                    wptr_next = wptr_reg + MAW'(1);
                    fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + (MAW+1)'(1);
                    if (state_reg == ARMED) begin
                        if (io.sti_tevent[0]) begin
                            pcnt_next = cfg_post_reg;
                            if (cfg_post_reg == 32'd0) enter_read = 1'b1;
                            else                       state_next = POST;
                        end
                    end else begin
                        pcnt_next = (pcnt_reg != 32'd0) ? pcnt_reg - 32'd1 : 32'd0;
                        if (pcnt_reg <= 32'd1) enter_read = 1'b1;
                    end
                end
            end
            READ: begin
                if (ctl_abort) begin
                    state_next = IDLE;
                    o_v        = 1'b0;
                    s_v        = 1'b0;
                    rem_next   = '0;
                end else begin
                    // Only fetch when the output + skid slots can absorb the
                    // word even if the consumer stalls for the next cycle.
                    if ((rem_reg != '0) && (held < 2'd2)) begin
                        issue          = 1'b1;
                        pend_next      = 1'b1;
                        pend_last_next = (rem_reg == (MAW+1)'(1));
                        rptr_next      = rptr_reg + MAW'(1);
                        rem_next       = rem_reg - (MAW+1)'(1);
                    end
                    if (pop) o_v = 1'b0;
                    if (!o_v && s_v) begin
                        out_data_next = skid_data_reg;
                        out_last_next = skid_last_reg;
                        o_v           = 1'b1;
                        s_v           = 1'b0;
                    end
                    if (pend_reg) begin
                        if (!o_v) begin
                            out_data_next = mem_q;
                            out_last_next = pend_last_reg;
                            o_v           = 1'b1;
                        end else begin
                            skid_data_next = mem_q;
                            skid_last_next = pend_last_reg;
                            s_v            = 1'b1;
                        end
                    end
                    if (pop && out_last_reg) begin
                        state_next = IDLE;
                        o_v        = 1'b0;
                        s_v        = 1'b0;
                        pend_next  = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (enter_read) begin
            state_next = READ;
            rptr_next  = wptr_next - fill_next[MAW-1:0];
            rem_next   = fill_next;
        end

        out_valid_next  = o_v;
        skid_valid_next = s_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            fill_reg       <= '0;
            rem_reg        <= '0;
            cfg_post_reg   <= '0;
            pcnt_reg       <= '0;
            pend_reg       <= 1'b0;
            pend_last_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wptr_reg       <= wptr_next;
            rptr_reg       <= rptr_next;
            fill_reg       <= fill_next;
            rem_reg        <= rem_next;
            cfg_post_reg   <= cfg_post_next;
            pcnt_reg       <= pcnt_next;
            pend_reg       <= pend_next;
            pend_last_reg  <= pend_last_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_last_reg  <= skid_last_next;
        end
    end

    // Capture memory: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_reg] <= io.sti_tdata;
        if (issue)  mem_q <= mem[rptr_reg];
    end
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture (D=16): the driver queues expected samples,
// a negedge monitor pops and compares on every output handshake.
module tb_trigger_capture;
    localparam int MAW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sts_state;

    trigger_capture_if #(.SEW(2), .SDW(32), .BAW(4), .BDW(32)) tif();

    trigger_capture #(.SDW(32), .MAW(MAW), .BAW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (tif.slave),
        .sts_state (sts_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          ready_mode = 0;
    logic [15:0] lfsr = 16'hACE1;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        tif.bus_wvalid = 1'b1;
        tif.bus_waddr  = a;
        tif.bus_wdata  = d;
        step();
        tif.bus_wvalid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] ev);
        tif.sti_tvalid = 1'b1;
        tif.sti_tdata  = d;
        tif.sti_tevent = ev;
        step();
        tif.sti_tvalid = 1'b0;
        tif.sti_tevent = 2'b00;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sts_state != 3'd0 || exp_q.size() != 0) && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_timeout: state %0d pending %0d, required state 0 pending 0",
                     name, sts_state, exp_q.size());
        end
    endtask

    // Sole driver of sto_tready: constant 1 or an LFSR pattern.
    initial begin
        tif.sto_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                tif.sto_tready = 1'b1;
            end else begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                tif.sto_tready = lfsr[0];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", 32'(tif.sto_tvalid), 32'd1);
                check("stall_data", tif.sto_tdata, prev_data);
                check("stall_last", 32'(tif.sto_tlast), 32'(prev_last));
            end
            if (tif.sto_tvalid && tif.sto_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d, required no output", tif.sto_tdata);
                end else begin
                    e = exp_q.pop_front();
                    $display("out data=%0d last=%0b (expected data=%0d last=%0b)",
                             tif.sto_tdata, tif.sto_tlast, e[31:0], e[32]);
                    check("out_data", tif.sto_tdata, e[31:0]);
                    check("out_last", 32'(tif.sto_tlast), 32'(e[32]));
                end
            end
            prev_stall = tif.sto_tvalid && !tif.sto_tready;
            prev_data  = tif.sto_tdata;
            prev_last  = tif.sto_tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        tif.bus_wvalid = 1'b0;
        tif.bus_waddr  = '0;
        tif.bus_wdata  = '0;
        tif.sti_tvalid = 1'b0;
        tif.sti_tevent = '0;
        tif.sti_tdata  = '0;

        #12;
        check("rst_tvalid", 32'(tif.sto_tvalid), 32'd0);
        check("rst_tlast", 32'(tif.sto_tlast), 32'd0);
        check("rst_tdata", tif.sto_tdata, 32'd0);
        check("rst_state", 32'(sts_state), 32'd0);
        check("bus_wready", 32'(tif.bus_wready), 32'd1);
        check("sti_tready", 32'(tif.sti_tready), 32'd1);
        rst = 1'b0;
        step();

        // 1..10, trigger on 6, three post samples -> 1..9
        bus_write(4'd1, 32'd3);
        bus_write(4'd0, 32'd1);
        check("t1_armed", 32'(sts_state), 32'd1);
        for (int i = 1; i <= 9; i++) push(32'(i), i == 9);
        for (int i = 1; i <= 10; i++) begin
            send(32'(i), (i == 6) ? 2'b01 : 2'b00);
            if (i == 6) check("t1_post", 32'(sts_state), 32'd2);
        end
        wait_done("t1");

        // 1..40, trigger on 30, two post samples -> wrapped window 17..32
        bus_write(4'd1, 32'd2);
        bus_write(4'd0, 32'd1);
        for (int i = 17; i <= 32; i++) push(32'(i), i == 32);
        for (int i = 1; i <= 40; i++) send(32'(i), (i == 30) ? 2'b01 : 2'b00);
        wait_done("t2");

        // cfg_post=0, trigger on first sample -> one sample with tlast
        bus_write(4'd1, 32'd0);
        bus_write(4'd0, 32'd1);
        push(32'd5, 1'b1);
        send(32'd5, 2'b01);
        check("t3_read", 32'(sts_state), 32'd3);
        wait_done("t3");

        // arm together with abort stays idle
        bus_write(4'd0, 32'd3);
        check("arm_abort_idle", 32'(sts_state), 32'd0);

        // event abort (trigger+abort) on sample 5, then re-arm
        bus_write(4'd0, 32'd1);
        for (int i = 1; i <= 4; i++) send(32'(i), 2'b00);
        send(32'd5, 2'b11);
        check("t4_abort_idle", 32'(sts_state), 32'd0);
        bus_write(4'd0, 32'd1);
        push(32'd7, 1'b1);
        send(32'd7, 2'b01);
        wait_done("t4");

        // 16-sample readout under a random ready pattern
        ready_mode = 1;
        bus_write(4'd0, 32'd1);
        for (int i = 201; i <= 216; i++) push(32'(i), i == 216);
        for (int i = 201; i <= 216; i++) send(32'(i), (i == 216) ? 2'b01 : 2'b00);
        wait_done("t5");
        ready_mode = 0;
        step();
        step();

        // bus abort landing on the 4th handshake
        bus_write(4'd0, 32'd1);
        for (int i = 301; i <= 304; i++) push(32'(i), 1'b0);
        base = hs_count;
        for (int i = 301; i <= 316; i++) send(32'(i), (i == 316) ? 2'b01 : 2'b00);
        n = 0;
        while (!(hs_count == base + 3 && tif.sto_tvalid && tif.sto_tready) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL t6_timeout: handshakes %0d, required %0d", hs_count - base, 3);
        end
        bus_write(4'd0, 32'd2);
        check("t6_tvalid_low", 32'(tif.sto_tvalid), 32'd0);
        check("t6_idle", 32'(sts_state), 32'd0);
        step();
        check("t6_handshakes", 32'(hs_count - base), 32'd4);

        // asynchronous reset while in POST
        bus_write(4'd1, 32'd10);
        bus_write(4'd0, 32'd1);
        send(32'd1, 2'b00);
        send(32'd2, 2'b01);
        check("t7_post", 32'(sts_state), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_state", 32'(sts_state), 32'd0);
        check("t7_rst_tvalid", 32'(tif.sto_tvalid), 32'd0);
        check("t7_rst_tlast", 32'(tif.sto_tlast), 32'd0);
        check("t7_rst_tdata", tif.sto_tdata, 32'd0);
        #3 rst = 1'b0;
        step();
        // cfg_post must be back to 0: a trigger goes straight to READ
        bus_write(4'd0, 32'd1);
        push(32'd9, 1'b1);
        send(32'd9, 2'b01);
        wait_done("t7");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
